ob_mem_unloader: RTL and testbench

OB_MEM_UNLOADER -- requirements
Module: ob_mem_unloader

---
 rtl/ob_mem_unloader.sv | 122 ++++++++++++
 tb/tb_ob_mem_unloader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_mem_unloader.sv
// rtl/ob_mem_unloader.sv - unloads output-buffer rows and streams each word out as LSB-first beats
module ob_mem_unloader #(
  parameter int WIDTH        = 16,
  parameter int COL          = 4,
  parameter int O_SIZE       = 256,
  parameter int DRIVER_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_async_i,
  input  logic                        start_i,
  input  logic [$clog2(O_SIZE)-1:0]   base_addr_i,
  input  logic [$clog2(O_SIZE):0]     num_rows_i,
  output logic                        mem_cenb_o,
  output logic                        mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0]   mem_addr_o,
  input  logic [COL*WIDTH-1:0]        mem_data_i,
  output logic [DRIVER_WIDTH-1:0]     data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int AW    = $clog2(O_SIZE);
  localparam int DW    = COL * WIDTH;
  localparam int BEATS = DW / DRIVER_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [AW:0]    ONE_ROW   = 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(O_SIZE - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic [AW:0]    rows_q;
  logic [BCW-1:0] beat_q;
  logic [DW-1:0]  shift_q;
  logic           accept;
  logic           last_beat;

  assign accept    = (state_q == S_SEND) && ready_i;
  assign last_beat = (beat_q == LAST_BEAT);

  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (num_rows_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_SEND;
      S_SEND: begin
        if (accept && last_beat) begin
          state_d = (rows_q == ONE_ROW) ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Config is only latched in IDLE, so a start pulse mid-run cannot disturb it.
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      addr_q  <= '0;
      rows_q  <= '0;
      beat_q  <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= base_addr_i;
            rows_q <= num_rows_i;
          end
        end
        S_WAIT: begin
          shift_q <= mem_data_i;
          beat_q  <= '0;
        end
        S_SEND: begin
          if (ready_i) begin
            shift_q <= shift_q >> DRIVER_WIDTH;
            beat_q  <= beat_q + BCW'(1);
            if (last_beat) begin
              addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
              rows_q <= rows_q - ONE_ROW;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registers so reset reaches them without a clock.
  assign mem_cenb_o = (state_q != S_READ);
  assign mem_wenb_o = 1'b1;
  assign mem_addr_o = addr_q;
  assign data_o     = shift_q[DRIVER_WIDTH-1:0];
  assign valid_o    = (state_q == S_SEND);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_ob_mem_unloader.sv
// tb/tb_ob_mem_unloader.sv - self-checking bench for ob_mem_unloader
module tb_ob_mem_unloader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  num_rows;
  logic        mem_cenb;
  logic        mem_wenb;
  logic [7:0]  mem_addr;
  logic [63:0] mem_data;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;

  logic [63:0] mem [0:255];
  logic [7:0]  exp_addr [$];
  logic [15:0] exp_beats [$];
  int          checks;
  int          errors;
  int          done_seen;
  int          exp_done;
  bit          prev_hold;
  logic [15:0] prev_data;

  ob_mem_unloader dut (
    .clk_i        (clk),
    .rstn_async_i (rstn),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .num_rows_i   (num_rows),
    .mem_cenb_o   (mem_cenb),
    .mem_wenb_o   (mem_wenb),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read output buffer: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (!mem_cenb) mem_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Model: a run is just the list of rows it reads and the LSB-first columns of each row.
  task automatic start_run(input int b, input int rows, input bit accepted);
    @(posedge clk);
    #1;
    start     = 1;
    base_addr = 8'(b);
    num_rows  = 9'(rows);
    if (accepted) begin
      for (int r = 0; r < rows; r++) begin
        exp_addr.push_back(8'((b + r) % 256));
        for (int c = 0; c < 4; c++)
          exp_beats.push_back(16'(mem[(b + r) % 256] >> (16 * c)));
      end
      exp_done++;
    end
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= limit) fail({name, "_timeout"});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      prev_hold = 0;
    end else begin
      chk("wenb_high", mem_wenb, 1);
      if (!mem_cenb) begin
        if (exp_addr.size() == 0) fail("unexpected_read");
        else chk("read_addr", mem_addr, exp_addr.pop_front());
      end
      if (prev_hold) begin
        chk("hold_valid", valid, 1);
        chk("hold_data", data, prev_data);
      end
      if (valid && ready) begin
        if (exp_beats.size() == 0) fail("extra_beat");
        else chk("beat_data", data, exp_beats.pop_front());
      end
      if (done) begin
        done_seen++;
        chk("done_after_last_beat", exp_beats.size(), 0);
      end
      prev_hold = valid && !ready;
      prev_data = data;
    end
  end

  initial begin
    int hold_cnt;
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    exp_done  = 0;
    prev_hold = 0;
    start     = 0;
    base_addr = 0;
    num_rows  = 0;
    ready     = 1;
    rstn      = 1;
    for (int a = 0; a < 256; a++)
      mem[a] = {16'(a * 16 + 4), 16'(a * 16 + 3), 16'(a * 16 + 2), 16'(a * 16 + 1)};
    mem[5] = 64'h0004_0003_0002_0001;

    #3 rstn = 0;
    #1;
    chk("rst_cenb", mem_cenb, 1);
    chk("rst_wenb", mem_wenb, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;

    // Single row, cycle-exact timing against hand-computed values.
    start_run(5, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      case (k)
        1: begin chk("c1_cenb", mem_cenb, 0); chk("c1_addr", mem_addr, 5); chk("c1_busy", busy, 1); end
        2: begin chk("c2_cenb", mem_cenb, 1); chk("c2_valid", valid, 0); end
        3, 4, 5, 6: begin chk("send_valid", valid, 1); chk("send_data", data, k - 2); chk("send_done", done, 0); end
        7: begin chk("c7_done", done, 1); chk("c7_valid", valid, 0); chk("c7_busy", busy, 1); end
        default: begin chk("c8_busy", busy, 0); chk("c8_done", done, 0); end
      endcase
    end

    // Backpressure on beat 2 for three cycles.
    hold_cnt = 0;
    start_run(5, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (valid && data == 16'h0003) hold_cnt++;
      @(posedge clk);
      #1;
      ready = (k + 1 < 5) || (k + 1 > 7);
    end
    chk("bp_hold_cycles", hold_cnt, 4);
    ready = 1;

    // Address wrap across the top of the buffer.
    start_run(254, 3, 1);
    wait_done("wrap", 60);
    chk("wrap_done_count", done_seen, exp_done);

    // Zero rows: immediate completion with no memory access.
    start_run(0, 0, 1);
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    chk("z_cenb", mem_cenb, 1);
    chk("z_valid", valid, 0);
    @(negedge clk);
    chk("z_busy_after", busy, 0);
    chk("z_done_after", done, 0);

    // Random backpressure over several rows.
    start_run(20, 4, 1);
    for (int n = 0; n < 400 && exp_done != done_seen; n++) begin
      @(posedge clk);
      #1 ready = 1'($urandom_range(0, 1));
    end
    ready = 1;
    chk("rand_done_count", done_seen, exp_done);

    // Reset during row 2, beat 1.
    start_run(10, 2, 1);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_rst_valid", valid, 1);
    chk("pre_rst_data", data, 16'(mem[11] >> 16));
    rstn = 0;
    exp_done--;
    exp_beats.delete();
    exp_addr.delete();
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cenb", mem_cenb, 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", data, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    start_run(0, 1, 1);
    wait_done("after_reset", 30);

    // Start pulse during SEND must be ignored.
    start_run(0, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    start     = 1;
    base_addr = 100;
    num_rows  = 5;
    @(posedge clk);
    #1 start = 0;
    wait_done("ignore_start", 40);
    repeat (4) @(negedge clk);
    chk("ign_idle", busy, 0);

    chk("final_done_count", done_seen, exp_done);
    chk("final_beats_left", exp_beats.size(), 0);
    chk("final_reads_left", exp_addr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
